rx_stream_sched: RTL

- Scheduler between the two RX complex FIFOs (0.9 GHz and 2.4 GHz channels) and the SMI byte path.
- Arbitrates which FIFO is read, issues single-cycle pull strobes, and captures each 32-bit I/Q word.
- Serialises each captured word MSB-first into a byte stream with a valid/ready handshake, tagging every byte with its source channel.
- Keeps sticky per-channel overflow flags for the status registers.

---
 rtl/rx_stream_sched.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_stream_sched.sv
// rx_stream_sched: picks which RX complex FIFO (0.9 GHz or 2.4 GHz) to read,
// pulls one 32-bit I/Q word at a time, and serialises it MSB-first as a tagged
// byte stream. It also keeps sticky per-channel overflow flags for status.
//
// Byte handshake: a byte is transferred on every rising clock edge where
// o_byte_valid and i_byte_ready are both high. Once o_byte_valid rises it
// stays high, and o_byte/o_byte_chan/o_byte_last stay stable, until that
// transfer happens. The consumer may hold i_byte_ready low for as long as it
// needs to.
module rx_stream_sched #(
  parameter int BURST_W = 8
) (
  input  logic               i_sys_clk,
  input  logic               i_rst_b,
  input  logic               i_enable,
  input  logic [1:0]         i_mode,
  input  logic [BURST_W-1:0] i_burst_len,
  input  logic               i_clear_status,
  output logic               o_fifo_09_pull,
  input  logic [31:0]        i_fifo_09_data,
  input  logic               i_fifo_09_empty,
  input  logic               i_fifo_09_full,
  output logic               o_fifo_24_pull,
  input  logic [31:0]        i_fifo_24_data,
  input  logic               i_fifo_24_empty,
  input  logic               i_fifo_24_full,
  output logic [7:0]         o_byte,
  output logic               o_byte_valid,
  input  logic               i_byte_ready,
  output logic               o_byte_chan,
  output logic               o_byte_last,
  output logic               o_overflow_09,
  output logic               o_overflow_24,
  output logic               o_busy,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {IDLE, PULL, CAPT, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               chan_q, chan_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [31:0]        word_q, word_d;
  logic               ovf_09_q, ovf_24_q;

  logic               sel_chan;
  logic [BURST_W-1:0] sel_cnt;
  logic [BURST_W-1:0] len_eff;
  logic [BURST_W:0]   cnt_inc;

  // Reserved mode 11 behaves exactly like 09-only.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  function automatic logic chan_empty(input logic c, input logic e09, input logic e24);
    return c ? e24 : e09;
  endfunction

  // A burst length of 0 is treated as 1 word per turn.
  assign len_eff = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
  assign cnt_inc = {1'b0, cnt_q} + (BURST_W+1)'(1);

  // State and datapath registers.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      chan_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  // Sticky overflow flags; a set in the same cycle as a clear wins.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      ovf_09_q <= 1'b0;
      ovf_24_q <= 1'b0;
    end else begin
      ovf_09_q <= (i_fifo_09_full && i_enable) || (ovf_09_q && !i_clear_status);
      ovf_24_q <= (i_fifo_24_full && i_enable) || (ovf_24_q && !i_clear_status);
    end
  end

  // Next-state: channel arbitration, burst accounting and byte indexing.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    word_d   = word_q;
    sel_chan = chan_q;
    sel_cnt  = cnt_q;
    case (state_q)
      IDLE: begin
        mode_d = eff_mode(i_mode);
        case (eff_mode(i_mode))
          2'b01: begin
            sel_chan = 1'b1;
            sel_cnt  = '0;
          end
          2'b10: begin
            // Stay on the current channel unless it is dry and the other is not.
            if (chan_empty(chan_q, i_fifo_09_empty, i_fifo_24_empty) &&
                !chan_empty(!chan_q, i_fifo_09_empty, i_fifo_24_empty)) begin
              sel_chan = !chan_q;
              sel_cnt  = '0;
            end
          end
          default: begin
            sel_chan = 1'b0;
            sel_cnt  = '0;
          end
        endcase
        if (i_enable && !chan_empty(sel_chan, i_fifo_09_empty, i_fifo_24_empty)) begin
          state_d = PULL;
          chan_d  = sel_chan;
          cnt_d   = sel_cnt;
        end
      end
      PULL: begin
        state_d = CAPT;
      end
      CAPT: begin
        word_d  = chan_q ? i_fifo_24_data : i_fifo_09_data;
        idx_d   = 2'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (i_byte_ready) begin
          if (idx_q == 2'd3) begin
            case (mode_q)
              2'b01: begin
                sel_chan = 1'b1;
                sel_cnt  = '0;
              end
              2'b10: begin
                if (cnt_inc >= {1'b0, len_eff}) begin
                  sel_chan = !chan_q;
                  sel_cnt  = '0;
                end else begin
                  sel_chan = chan_q;
                  sel_cnt  = cnt_inc[BURST_W-1:0];
                end
                // Work-conserving: never wait on a dry channel while the other has data.
                if (chan_empty(sel_chan, i_fifo_09_empty, i_fifo_24_empty) &&
                    !chan_empty(!sel_chan, i_fifo_09_empty, i_fifo_24_empty)) begin
                  sel_chan = !sel_chan;
                  sel_cnt  = '0;
                end
              end
              default: begin
                sel_chan = 1'b0;
                sel_cnt  = '0;
              end
            endcase
            chan_d  = sel_chan;
            cnt_d   = sel_cnt;
            idx_d   = 2'd0;
            state_d = (i_enable && !chan_empty(sel_chan, i_fifo_09_empty, i_fifo_24_empty))
                      ? PULL : IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output byte selection, MSB first; zero outside SHIFT.
  always_comb begin
    o_byte = 8'd0;
    if (state_q == SHIFT) begin
      case (idx_q)
        2'd0:    o_byte = word_q[31:24];
        2'd1:    o_byte = word_q[23:16];
        2'd2:    o_byte = word_q[15:8];
        default: o_byte = word_q[7:0];
      endcase
    end
  end

  // Pulls are gated by the empty flags so a dry FIFO is never read.
  assign o_fifo_09_pull = (state_q == PULL) && !chan_q && !i_fifo_09_empty;
  assign o_fifo_24_pull = (state_q == PULL) &&  chan_q && !i_fifo_24_empty;
  assign o_byte_valid   = (state_q == SHIFT);
  assign o_byte_chan    = (state_q == SHIFT) && chan_q;
  assign o_byte_last    = (state_q == SHIFT) && (idx_q == 2'd3);
  assign o_overflow_09  = ovf_09_q;
  assign o_overflow_24  = ovf_24_q;
  assign o_busy         = (state_q != IDLE);
  assign o_dbg_state    = state_q;

endmodule
